// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and a valid/ready result port.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       MulDivSel,
    input  logic [WIDTH-1:0] MDA,
    input  logic [WIDTH-1:0] MDB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] MDOut,
    output logic             busy
);

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t               state, state_nxt;
    logic [2:0]           op;
    logic [WIDTH-1:0]     opnd;      // multiplicand for MUL*, divisor for DIV*/REM*
    logic [2*WIDTH-1:0]   acc;       // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]        count;
    logic                 neg_q, neg_r, special;

    logic                 a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 div_zero, div_ovf, is_special;
    logic [WIDTH-1:0]     special_res;

    logic [WIDTH:0]       mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix, result;

    // Request decode: signedness, magnitudes and the divide fast paths.
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        a_signed    = MulDivSel inside {3'b001, 3'b010, 3'b100, 3'b110};
        b_signed    = MulDivSel inside {3'b001, 3'b100, 3'b110};
        a_neg       = a_signed & MDA[WIDTH-1];
        b_neg       = b_signed & MDB[WIDTH-1];
        a_mag       = a_neg ? -MDA : MDA;
        b_mag       = b_neg ? -MDB : MDB;
        div_zero    = (MDB == '0);
        div_ovf     = !MulDivSel[0] && (MDA == MIN_NEG) && (MDB == ALL_ONES);
        is_special  = MulDivSel[2] && (div_zero || div_ovf);
        special_res = MDA;
        if (div_zero)
            special_res = MulDivSel[1] ? MDA : ALL_ONES;
        else if (MulDivSel[1])
            special_res = '0;
    end

    // One radix-2 step of each algorithm; the carry bit keeps the partial sums exact.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        div_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_sh - {1'b0, opnd};
        div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        result   = quo_fix;
        if (special)
            result = acc[WIDTH-1:0];
        else begin
            case (op)
                3'b000:                 result = prod_fix[WIDTH-1:0];
                3'b001, 3'b010, 3'b011: result = prod_fix[2*WIDTH-1:WIDTH];
                3'b110, 3'b111:         result = rem_fix;
                default:                result = quo_fix;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid && !flush) state_nxt = is_special ? FIX : BUSY;
            BUSY: if (flush) state_nxt = IDLE;
                  else if (count == LAST) state_nxt = FIX;
            FIX:  state_nxt = flush ? IDLE : DONE;
            DONE: if (flush || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op      <= '0;
            opnd    <= '0;
            acc     <= '0;
            count   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
            MDOut   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && !flush) begin
                    op      <= MulDivSel;
                    count   <= '0;
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    special <= is_special;
                    if (is_special) begin
                        acc  <= {{WIDTH{1'b0}}, special_res};
                        opnd <= '0;
                    end else if (MulDivSel[2]) begin
                        acc  <= {{WIDTH{1'b0}}, a_mag};
                        opnd <= b_mag;
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, b_mag};
                        opnd <= a_mag;
                    end
                end
                BUSY: begin
                    acc   <= op[2] ? div_next : mul_next;
                    count <= count + CW'(1);
                end
                FIX: if (!flush) MDOut <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit: a driver queues expected results from
// a plain-arithmetic RV32M model; a monitor checks results, latency and hold behaviour.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, out_ready, in_ready, out_valid, busy;
    logic [2:0]   sel;
    logic [W-1:0] mda, mdb, mdout;

    typedef struct {
        logic [W-1:0] exp;
        int           lat;
    } exp_t;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, exp;
        int           lat;
    } dir_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, accept_cyc = 0, last_xfer = 0, force_low = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .MulDivSel(sel), .MDA(mda), .MDB(mdb), .out_valid(out_valid), .out_ready(out_ready),
        .MDOut(mdout), .busy(busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RV32M reference in 64-bit integer arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint       sa, sb_, ua, ub;
        logic [63:0]  t;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        case (op)
            3'd0: t = sa * sb_;
            3'd1: begin t = sa * sb_; return t[63:32]; end
            3'd2: begin t = sa * ub;  return t[63:32]; end
            3'd3: begin t = ua * ub;  return t[63:32]; end
            3'd4: begin
                if (b == 0) return '1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                t = sa / sb_;
            end
            3'd5: begin if (b == 0) return '1; t = ua / ub; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                t = sa % sb_;
            end
            default: begin if (b == 0) return a; t = ua % ub; end
        endcase
        return t[W-1:0];
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return W + 1;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat);
        int waited = 0;
        @(negedge clk);
        while (!(in_ready && !flush)) begin
            waited++;
            if (waited > 200) begin
                check("issue_timeout", 32'(waited), 32'd0);
                return;
            end
            @(negedge clk);
        end
        sel = op; mda = a; mdb = b; in_valid = 1'b1;
        sb.push_back('{exp, lat});
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        sel = 3'($urandom); mda = $urandom; mdb = $urandom;
    endtask

    task automatic issue_rand(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b, model(op, a, b), latency(op, a, b));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin @(negedge clk); n++; end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Consumer back-pressure: random, or forced low for a counted number of DONE cycles.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (force_low > 0) begin
                out_ready = 1'b0;
                if (out_valid) force_low--;
            end else
                out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency at first out_valid, stability while held, result at transfer.
    initial begin
        logic         seen = 1'b0;
        logic [W-1:0] held = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                seen = 1'b0;
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    held = mdout;
                    if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                    else check("latency", 32'(cyc - accept_cyc), 32'(sb[0].lat));
                end else
                    check("hold_mdout", mdout, held);
                check("in_ready_in_done", 32'(in_ready), 32'd0);
                if (out_ready && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result", mdout, e.exp);
                    last_xfer = cyc + 1;
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_t dirs[12];
        dirs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        dirs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        dirs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        dirs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        dirs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 33};
        dirs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 33};
        dirs[6]  = '{3'd5, 32'd100,        32'd7,          32'd14,         33};
        dirs[7]  = '{3'd7, 32'd100,        32'd7,          32'd2,          33};
        dirs[8]  = '{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 1};
        dirs[9]  = '{3'd6, 32'd5,          32'd0,          32'd5,          1};
        dirs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        dirs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = '0; mda = '0; mdb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_mdout", mdout, 32'd0);
        rst_n = 1'b1;

        foreach (dirs[i]) issue(dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].exp, dirs[i].lat);
        drain();

        // Long hold in DONE, then the next request must be accepted on the following edge.
        force_low = 10;
        issue(3'd5, 32'd1000, 32'd9, 32'd111, 33);
        issue(3'd0, 32'd12, 32'd12, 32'd144, 33);
        check("accept_after_release", 32'(accept_cyc), 32'(last_xfer + 1));
        drain();

        // flush in IDLE must block acceptance.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; sel = 3'd5; mda = 32'd9; mdb = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("idle_flush_blocks", 32'(busy), 32'd0);

        // flush on the tenth edge of a DIV.
        issue(3'd4, 32'd1234, 32'd5, 32'd246, 33);
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        void'(sb.pop_back());
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        issue(3'd5, 32'd9, 32'd3, 32'd3, 33);
        drain();

        // reset on the twentieth edge of a MUL.
        issue(3'd0, 32'd77, 32'd55, 32'd4235, 33);
        repeat (19) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        void'(sb.pop_back());
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mdout", mdout, 32'd0);
        issue(3'd5, 32'd9, 32'd3, 32'd3, 33);
        drain();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) force_low = $urandom_range(1, 4);
            issue_rand(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
